mux4to1_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the `mux4to1` block. It drives the mux select lines `s1`/`s0` through channels 0..3, samples the mux output `y` once per channel and assembles the four samples into a 4-bit frame. The frame is handed downstream on a valid/ready handshake. The block turns the combinational 4:1 mux into a time-division scanner of four 1-bit sources.

---
 rtl/mux4to1_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux4to1_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1_scan_ctrl.sv
// Time-division scanner in front of a 4:1 mux: steps the selects through channels 0..3,
// samples y once per channel and hands the assembled 4-bit frame out on valid/ready.
module mux4to1_scan_ctrl #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t          state_r;
  logic [1:0]      ch_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      shd_r;

  // Scan sequencer: state, channel/hold counters, shadow capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ch_r        <= 2'd0;
      cnt_r       <= '0;
      shd_r       <= 4'h0;
      s1          <= 1'b0;
      s0          <= 1'b0;
      frame       <= 4'h0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          {s1, s0}    <= 2'b00;
          frame_valid <= 1'b0;
          if (start) begin
            state_r <= SCAN;
            ch_r    <= 2'd0;
            cnt_r   <= '0;
            shd_r   <= 4'h0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        SCAN: begin
          if (cnt_r == CNT_MAX) begin
            shd_r[ch_r] <= y;
            cnt_r       <= '0;
            ch_r        <= ch_r + 2'd1;
            if (ch_r == 2'd3) begin
              // Channel 3 goes straight from y into the frame; shd_r[3] is still clear here.
              state_r     <= VALID;
              frame       <= (shd_r & 4'b0111) | {y, 3'b000};
              frame_valid <= 1'b1;
              {s1, s0}    <= 2'b00;
            end else begin
              state_r  <= SCAN;
              {s1, s0} <= ch_r + 2'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        VALID: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (cont) begin
              state_r <= SCAN;
              ch_r    <= 2'd0;
              cnt_r   <= '0;
              shd_r   <= 4'h0;
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            state_r <= VALID;
          end
        end
        default: begin
          state_r     <= IDLE;
          {s1, s0}    <= 2'b00;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4to1_scan_ctrl.sv
// Self-checking bench: two scanners (HOLD=1 and HOLD=3) each feeding a behavioural 4:1 mux.
module tb_mux4to1_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, cont1, rdy1, u1_s1, u1_s0, fv1, busy1, y1;
  logic [3:0] d1, frame1;
  logic       start3, cont3, rdy3, u3_s1, u3_s0, fv3, busy3, y3;
  logic [3:0] d3, frame3;

  int checks = 0;
  int errors = 0;
  logic [3:0] q1[$];
  logic [3:0] q3[$];

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[16];

  // Behavioural mux4to1 models closing the loop from selects back to y.
  assign y1 = d1[{u1_s1, u1_s0}];
  assign y3 = d3[{u3_s1, u3_s0}];

  mux4to1_scan_ctrl #(.HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .y(y1),
    .s1(u1_s1), .s0(u1_s0), .frame(frame1), .frame_valid(fv1),
    .frame_ready(rdy1), .busy(busy1)
  );

  mux4to1_scan_ctrl #(.HOLD(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cont(cont3), .y(y3),
    .s1(u3_s1), .s0(u3_s0), .frame(frame3), .frame_valid(fv3),
    .frame_ready(rdy3), .busy(busy3)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the HOLD=1 scanner: a handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fv1 === 1'b1 && rdy1 === 1'b1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected actual=%0h required=none", frame1);
      end else begin
        check("sb1_frame", {28'd0, frame1}, {28'd0, q1.pop_front()});
      end
    end
  end

  // Scoreboard for the HOLD=3 scanner.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fv3 === 1'b1 && rdy3 === 1'b1) begin
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL sb3_unexpected actual=%0h required=none", frame3);
      end else begin
        check("sb3_frame", {28'd0, frame3}, {28'd0, q3.pop_front()});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Main stimulus sequence.
  initial begin
    int lat;
    for (int i = 0; i < 16; i++) begin
      vecs[i].d   = 4'(i);
      vecs[i].exp = 4'(i);
    end

    rst_n = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; rdy1 = 1'b1; d1 = 4'h0;
    start3 = 1'b0; cont3 = 1'b0; rdy3 = 1'b1; d3 = 4'h0;
    tick();
    tick();
    check("rst_u1", {u1_s1, u1_s0, frame1, fv1, busy1}, 8'h00);
    check("rst_u3", {u3_s1, u3_s0, frame3, fv3, busy3}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy1, 1'b0);

    // Basic scan: d0..d3 = 0,1,0,1.
    d1 = 4'b1010;
    q1.push_back(4'hA);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("basic_sel", {u1_s1, u1_s0}, k);
      check("basic_busy", busy1, 1'b1);
      check("basic_fv_low", fv1, 1'b0);
      tick();
    end
    check("basic_fv", fv1, 1'b1);
    check("basic_frame", frame1, 4'hA);
    check("basic_sel_valid", {u1_s1, u1_s0}, 2'b00);
    tick();
    check("basic_idle", {busy1, fv1}, 2'b00);

    // Select coverage over all 16 source patterns.
    for (int i = 0; i < 16; i++) begin
      d1 = vecs[i].d;
      q1.push_back(vecs[i].exp);
      start1 = 1'b1; tick(); start1 = 1'b0;
      lat = 0;
      while (fv1 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      check("cov_latency", lat, 4);
      tick();
      check("cov_idle", busy1, 1'b0);
    end

    // Backpressure: frame held for 10 cycles while sources change.
    rdy1 = 1'b0;
    d1 = 4'b0110;
    q1.push_back(4'h6);
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      d1 = ~d1;
      check("bp_fv", fv1, 1'b1);
      check("bp_frame", frame1, 4'h6);
      check("bp_sel", {u1_s1, u1_s0}, 2'b00);
      check("bp_busy", busy1, 1'b1);
      tick();
    end
    rdy1 = 1'b1;
    tick();
    check("bp_release", {busy1, fv1}, 2'b00);

    // Continuous mode: back-to-back frames 5 cycles apart.
    cont1 = 1'b1;
    d1 = 4'b1010;
    q1.push_back(4'hA);
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (3) tick();
    check("cont_fv_early", fv1, 1'b0);
    tick();
    check("cont_fv_a", fv1, 1'b1);
    check("cont_frame_a", frame1, 4'hA);
    d1 = 4'hF;
    q1.push_back(4'hF);
    tick();
    check("cont_no_bubble", {busy1, fv1, u1_s1, u1_s0}, 4'b1000);
    repeat (3) tick();
    check("cont_fv_mid", fv1, 1'b0);
    tick();
    check("cont_fv_f", fv1, 1'b1);
    check("cont_frame_f", frame1, 4'hF);
    cont1 = 1'b0;
    tick();
    check("cont_stop", {busy1, fv1}, 2'b00);

    // Hold stretch on the HOLD=3 scanner: d = 1,1,0,0.
    d3 = 4'b0011;
    q3.push_back(4'h3);
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("hold_sel", {u3_s1, u3_s0}, k / 3);
      check("hold_fv_low", fv3, 1'b0);
      tick();
    end
    check("hold_fv", fv3, 1'b1);
    check("hold_frame", frame3, 4'h3);
    tick();
    check("hold_idle", busy3, 1'b0);

    // Reset mid-scan after channel 1 has been sampled.
    d1 = 4'hF;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_u1", {u1_s1, u1_s0, frame1, fv1, busy1}, 8'h00);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midrst_quiet", {busy1, fv1}, 2'b00);
    end

    // Start while busy is ignored: only one frame, then idle.
    d1 = 4'b0101;
    q1.push_back(4'h5);
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    tick();
    check("ign_fv", fv1, 1'b1);
    check("ign_frame", frame1, 4'h5);
    tick();
    check("ign_idle", {busy1, fv1}, 2'b00);
    tick();
    check("ign_still_idle", busy1, 1'b0);

    check("sb1_drained", q1.size(), 0);
    check("sb3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
